// File: rtl/spi_norflash_slave.sv
// NOR-flash device model behind a byte-wide SPI port, fully synchronous to p_clk.
// Define SPI_FLASH_BURST_EN to let a frame stream consecutive words with auto-incrementing address.
module spi_norflash_slave #(
    parameter int           DEPTH       = 16,
    parameter int           ADDR_W      = 4,
    parameter int           SYNC_STAGES = 2,
    parameter logic [7:0]   OP_WRITE    = 8'h02,
    parameter logic [7:0]   OP_READ     = 8'h01
) (
    input  logic            p_clk,
    input  logic            p_reset_n,
    input  logic            s_clk,
    input  logic            s_css,
    input  logic [7:0]      s_mosi,
    output logic [7:0]      s_miso,
    output logic            wr_done,
    output logic            cmd_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] css_sync_q;
    logic [7:0]             mosi_sync_q [SYNC_STAGES];
    logic                   sclk_prev_q;
    logic                   css_prev_q;

    logic                   sclk_s;
    logic                   css_s;
    logic [7:0]             mosi_s;
    logic                   rise;
    logic                   css_toggle;

    state_t                 state_q;
    logic [7:0]             k_q;
    logic                   is_read_q;
    logic [ADDR_W-1:0]      idx_q;
    logic [1:0]             beat_q;
    logic [23:0]            wdata_q;
    logic [31:0]            mem_q [DEPTH];
    logic [7:0]             miso_q;
    logic                   wr_done_q;
    logic                   cmd_err_q;

    logic [7:0]             k_d;
    logic [ADDR_W-1:0]      idx_d;
    logic [ADDR_W-1:0]      idx_inc;

    // mosi travels through the same number of stages as s_clk so the byte is stable at the detected edge
    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            sclk_sync_q <= '0;
            css_sync_q  <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= '0;
            end
            sclk_prev_q <= 1'b0;
            css_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
            css_sync_q     <= {css_sync_q[SYNC_STAGES-2:0], s_css};
            mosi_sync_q[0] <= s_mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
            css_prev_q  <= css_s;
        end
    end

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign css_s      = css_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign rise       = sclk_s & ~sclk_prev_q & ~css_s;
    assign css_toggle = css_s ^ css_prev_q;

    assign k_d     = (k_q == 8'hFF) ? k_q : k_q + 8'd1;
    // Shifting the address bytes in keeps only the low ADDR_W bits, so upper address bits wrap away
    assign idx_d   = ADDR_W'({idx_q, mosi_s});
    assign idx_inc = idx_q + ADDR_W'(1);

    always_ff @(posedge p_clk or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            is_read_q <= 1'b0;
            idx_q     <= '0;
            beat_q    <= '0;
            wdata_q   <= '0;
            miso_q    <= '0;
            wr_done_q <= 1'b0;
            cmd_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_done_q <= 1'b0;
            cmd_err_q <= 1'b0;
            if (css_toggle) begin
                state_q <= ST_IDLE;
                k_q     <= '0;
                beat_q  <= '0;
                miso_q  <= '0;
            end else if (rise) begin
                k_q <= k_d;
                case (state_q)
                    ST_IDLE: begin
                        if (mosi_s == OP_WRITE || mosi_s == OP_READ) begin
                            state_q   <= ST_ADDR;
                            is_read_q <= (mosi_s == OP_READ);
                        end else begin
                            state_q   <= ST_IGNORE;
                            cmd_err_q <= 1'b1;
                        end
                    end
                    ST_ADDR: begin
                        idx_q <= idx_d;
                        if (k_d == 8'd4) begin
                            state_q <= ST_DATA;
                            beat_q  <= '0;
                            if (is_read_q) begin
                                miso_q <= mem_q[idx_d][31:24];
                            end
                        end
                    end
                    ST_DATA: begin
                        beat_q  <= beat_q + 2'd1;
                        wdata_q <= {wdata_q[15:0], mosi_s};
                        if (is_read_q) begin
                            case (beat_q)
                                2'd0:    miso_q <= mem_q[idx_q][23:16];
                                2'd1:    miso_q <= mem_q[idx_q][15:8];
                                2'd2:    miso_q <= mem_q[idx_q][7:0];
                                default: begin
`ifdef SPI_FLASH_BURST_EN
                                    miso_q <= mem_q[idx_inc][31:24];
`else
                                    miso_q <= '0;
`endif
                                end
                            endcase
                        end
                        if (beat_q == 2'd3) begin
                            if (!is_read_q) begin
                                mem_q[idx_q] <= {wdata_q, mosi_s};
                                wr_done_q    <= 1'b1;
                            end
`ifdef SPI_FLASH_BURST_EN
                            idx_q <= idx_inc;
`else
                            state_q <= ST_IGNORE;
`endif
                        end
                    end
                    default: begin
                        miso_q <= '0;
                    end
                endcase
            end
        end
    end

    assign s_miso  = miso_q;
    assign wr_done = wr_done_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_norflash_slave.sv
// Directed frame-level bench for spi_norflash_slave: vector table of whole frames plus hand-written abort/reset/burst sequences.
module tb_spi_norflash_slave;

    logic       p_clk;
    logic       p_reset_n;
    logic       s_clk;
    logic       s_css;
    logic [7:0] s_mosi;
    logic [7:0] s_miso;
    logic       wr_done;
    logic       cmd_err;

    spi_norflash_slave dut (
        .p_clk     (p_clk),
        .p_reset_n (p_reset_n),
        .s_clk     (s_clk),
        .s_css     (s_css),
        .s_mosi    (s_mosi),
        .s_miso    (s_miso),
        .wr_done   (wr_done),
        .cmd_err   (cmd_err)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [31:0] data;
        int          nbytes;
        int          exp_wr;
        int          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NVEC = 12;
    vec_t       vecs [NVEC];
    logic [7:0] frame_bytes [16];
    logic [7:0] miso_seen [16];
    int         wr_total;
    int         err_total;
    int         wr_delta;
    int         err_delta;
    int         checks;
    int         failures;

    always @(negedge p_clk) begin
        if (wr_done) wr_total++;
        if (cmd_err) err_total++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge p_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
        s_mosi = b;
        tick(3);
        s_clk = 1'b1;
        tick(6);
        s_clk = 1'b0;
        tick(4);
        miso = s_miso;
    endtask

    task automatic run_frame(input int n);
        int wr0;
        int err0;
        logic [7:0] m;
        wr0  = wr_total;
        err0 = err_total;
        for (int i = 0; i < 16; i++) miso_seen[i] = 8'h00;
        s_css = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            send_byte(frame_bytes[i], m);
            miso_seen[i] = m;
        end
        s_css = 1'b1;
        tick(6);
        wr_delta  = wr_total - wr0;
        err_delta = err_total - err0;
    endtask

    task automatic load_bytes(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] d0, input logic [31:0] d1);
        for (int i = 0; i < 16; i++) frame_bytes[i] = 8'h00;
        frame_bytes[0]  = op;
        frame_bytes[1]  = addr[23:16];
        frame_bytes[2]  = addr[15:8];
        frame_bytes[3]  = addr[7:0];
        frame_bytes[4]  = d0[31:24];
        frame_bytes[5]  = d0[23:16];
        frame_bytes[6]  = d0[15:8];
        frame_bytes[7]  = d0[7:0];
        frame_bytes[8]  = d1[31:24];
        frame_bytes[9]  = d1[23:16];
        frame_bytes[10] = d1[15:8];
        frame_bytes[11] = d1[7:0];
    endtask

    function automatic logic [31:0] word_at(input int first);
        return {miso_seen[first], miso_seen[first+1], miso_seen[first+2], miso_seen[first+3]};
    endfunction

    task automatic read_word(input logic [23:0] addr, input string name, input logic [31:0] exp);
        load_bytes(8'h01, addr, 32'h0, 32'h0);
        run_frame(8);
        $display("read  addr=%h word=%h", addr, word_at(3));
        chk(name, word_at(3), exp);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        wr_total  = 0;
        err_total = 0;

        vecs[0]  = '{8'h02, 24'h000000, 32'hFF00FF00, 8,  1, 0, 32'h00000000};
        vecs[1]  = '{8'h01, 24'h000000, 32'h00000000, 8,  0, 0, 32'hFF00FF00};
        vecs[2]  = '{8'h9F, 24'h000000, 32'hDEADBEEF, 8,  0, 1, 32'h00000000};
        vecs[3]  = '{8'h01, 24'h000000, 32'h00000000, 8,  0, 0, 32'hFF00FF00};
        vecs[4]  = '{8'h02, 24'h000013, 32'h12345678, 8,  1, 0, 32'h00000000};
        vecs[5]  = '{8'h01, 24'h000003, 32'h00000000, 8,  0, 0, 32'h12345678};
        vecs[6]  = '{8'h01, 24'hA5C0F3, 32'h00000000, 8,  0, 0, 32'h12345678};
        vecs[7]  = '{8'h02, 24'h000005, 32'hAABBCCDD, 8,  1, 0, 32'h00000000};
        vecs[8]  = '{8'h02, 24'h000005, 32'h11223344, 6,  0, 0, 32'h00000000};
        vecs[9]  = '{8'h01, 24'h000005, 32'h00000000, 8,  0, 0, 32'hAABBCCDD};
        vecs[10] = '{8'h02, 24'h000007, 32'hCAFEF00D, 10, 1, 0, 32'h00000000};
        vecs[11] = '{8'h01, 24'h000007, 32'h00000000, 8,  0, 0, 32'hCAFEF00D};

        p_reset_n = 1'b0;
        s_clk     = 1'b0;
        s_css     = 1'b1;
        s_mosi    = 8'h00;
        tick(3);
        chk("reset_miso", {24'h0, s_miso}, 32'h0);
        chk("reset_wr_done", {31'h0, wr_done}, 32'h0);
        chk("reset_cmd_err", {31'h0, cmd_err}, 32'h0);
        p_reset_n = 1'b1;
        tick(4);

        for (int v = 0; v < NVEC; v++) begin
            load_bytes(vecs[v].op, vecs[v].addr, vecs[v].data, 32'h0);
            run_frame(vecs[v].nbytes);
            $display("frame %0d op=%h addr=%h data=%h n=%0d wr=%0d err=%0d word=%h last=%h",
                     v, vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].nbytes,
                     wr_delta, err_delta, word_at(3), miso_seen[7]);
            chk($sformatf("vec%0d_wr_done", v), wr_delta, vecs[v].exp_wr);
            chk($sformatf("vec%0d_cmd_err", v), err_delta, vecs[v].exp_err);
            if (vecs[v].nbytes >= 8) begin
                chk($sformatf("vec%0d_miso_word", v), word_at(3), vecs[v].exp_rd);
                chk($sformatf("vec%0d_miso_after8", v), {24'h0, miso_seen[7]}, 32'h0);
            end
        end

`ifdef SPI_FLASH_BURST_EN
        load_bytes(8'h02, 24'h00000F, 32'h11111111, 32'h22222222);
        run_frame(12);
        $display("burst write idx=F wr=%0d", wr_delta);
        chk("burst_wr_count", wr_delta, 2);
        load_bytes(8'h01, 24'h00000F, 32'h0, 32'h0);
        run_frame(12);
        $display("burst read idx=F w0=%h w1=%h last=%h", word_at(3), word_at(7), miso_seen[11]);
        chk("burst_rd_word0", word_at(3), 32'h11111111);
        chk("burst_rd_word1", word_at(7), 32'h22222222);
        chk("burst_rd_after12", {24'h0, miso_seen[11]}, 32'h0);
`endif

        // Reset in the middle of a write frame: nothing commits and the array is cleared.
        begin
            int wr0;
            logic [7:0] m;
            wr0 = wr_total;
            load_bytes(8'h02, 24'h000009, 32'hAABB0000, 32'h0);
            s_css = 1'b0;
            tick(4);
            for (int i = 0; i < 6; i++) send_byte(frame_bytes[i], m);
            p_reset_n = 1'b0;
            tick(2);
            chk("midreset_miso", {24'h0, s_miso}, 32'h0);
            p_reset_n = 1'b1;
            s_css     = 1'b1;
            tick(6);
            $display("mid-frame reset wr=%0d", wr_total - wr0);
            chk("midreset_no_wr_done", wr_total - wr0, 0);
        end
        read_word(24'h000000, "midreset_mem0_cleared", 32'h0);
        read_word(24'h000005, "midreset_mem5_cleared", 32'h0);
        read_word(24'h000009, "midreset_mem9_untouched", 32'h0);

        load_bytes(8'h02, 24'h000009, 32'h0BADF00D, 32'h0);
        run_frame(8);
        $display("post-reset write idx=9 wr=%0d", wr_delta);
        chk("postreset_wr_done", wr_delta, 1);
        read_word(24'h000009, "postreset_mem9", 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
